itlb_refill_ctrl: RTL and testbench

ITLB_REFILL_CTRL -- requirements
Module: itlb_refill_ctrl

---
 rtl/mms_pkg.sv | 23 ++
 rtl/itlb_victim_sel.sv | 25 ++
 rtl/itlb_refill_ctrl.sv | 142 ++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// Shared types and constants for the memory-management blocks.
// Supplies the ITLB refill FSM state encoding and the PTE/VPN sizes.
`ifndef MXLEN
`define MXLEN 64
`endif
`ifndef ITLB_ENTRY_SIZE
`define ITLB_ENTRY_SIZE 31
`endif

package mms_pkg;

  localparam int ITLB_VPN_W = 27;

  typedef logic [`MXLEN-1:0] pte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } itlb_refill_state_e;

endpackage

// File: rtl/itlb_victim_sel.sv
// Combinational ITLB victim choice: lowest invalid entry, else the
// round-robin pointer. use_rr flags that the pointer supplied the victim.
module itlb_victim_sel #(
  parameter int ENTRY_NUM = 31,
  parameter int PTR_W     = 5
) (
  input  logic [ENTRY_NUM-1:0] valid,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [PTR_W-1:0]     victim,
  output logic                 use_rr
);

  // Scan high to low so the lowest invalid index is the last one to win.
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim = PTR_W'(i);
        use_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: accepts a miss, issues a page-walk request,
// and writes the returned leaf PTE into a victim entry; flush invalidates all.
module itlb_refill_ctrl
  import mms_pkg::*;
#(
  parameter int ENTRY_NUM = `ITLB_ENTRY_SIZE,
  parameter int VPN_W     = ITLB_VPN_W
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 miss_valid_i,
  input  logic [VPN_W-1:0]     miss_vpn_i,
  output logic                 miss_ready_o,
  input  logic                 flush_i,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_resp_valid_i,
  input  logic [`MXLEN-1:0]    ptw_resp_pte_i,
  input  logic                 ptw_resp_fault_i,
  output logic [ENTRY_NUM-1:0] itlb_wr_en_o,
  output logic [`MXLEN-1:0]    itlb_pte_wr_o,
  output logic [VPN_W-1:0]     itlb_vpn_wr_o,
  output logic [ENTRY_NUM-1:0] entry_valid_o,
  output logic                 refill_done_o,
  output logic                 refill_fault_o
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  itlb_refill_state_e state, state_d;
  logic [VPN_W-1:0]     vpn_q;
  pte_t                 pte_q;
  logic                 drop_q, drop_d;
  logic                 fault_q, fault_d;
  logic [ENTRY_NUM-1:0] valid_q;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     victim;
  logic                 use_rr;
  logic                 write_go;
  logic [ENTRY_NUM-1:0] wr_en;

  itlb_victim_sel #(
    .ENTRY_NUM (ENTRY_NUM),
    .PTR_W     (PTR_W)
  ) u_victim_sel (
    .valid  (valid_q),
    .rr_ptr (rr_ptr),
    .victim (victim),
    .use_rr (use_rr)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      vpn_q   <= '0;
      pte_q   <= '0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
      valid_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
      if (state == IDLE && state_d == REQ)
        vpn_q <= miss_vpn_i;
      if (state == WAIT && state_d == WRITE)
        pte_q <= ptw_resp_pte_i;
      // Flush has priority over any write landing in the same cycle.
      if (flush_i) begin
        valid_q <= '0;
        rr_ptr  <= '0;
      end else if (write_go) begin
        valid_q <= valid_q | wr_en;
        if (use_rr)
          rr_ptr <= (rr_ptr == PTR_W'(ENTRY_NUM - 1)) ? '0 : rr_ptr + PTR_W'(1);
      end
    end
  end

  always_comb begin
    state_d         = state;
    drop_d          = drop_q;
    fault_d         = 1'b0;
    miss_ready_o    = 1'b0;
    ptw_req_valid_o = 1'b0;
    write_go        = 1'b0;
    case (state)
      IDLE: begin
        miss_ready_o = !flush_i;
        drop_d       = 1'b0;
        if (miss_valid_i && !flush_i)
          state_d = REQ;
      end
      REQ: begin
        ptw_req_valid_o = 1'b1;
        if (flush_i)
          drop_d = 1'b1;
        if (ptw_req_ready_i)
          state_d = WAIT;
      end
      WAIT: begin
        if (flush_i)
          drop_d = 1'b1;
        if (ptw_resp_valid_i) begin
          // A flushed walk is still consumed, but leaves no trace.
          if (drop_q || flush_i) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else if (ptw_resp_fault_i) begin
            state_d = IDLE;
            fault_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        write_go = !flush_i;
        drop_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      wr_en[i] = write_go && (victim == PTR_W'(i));
  end

  assign itlb_wr_en_o   = wr_en;
  assign itlb_pte_wr_o  = pte_q;
  assign itlb_vpn_wr_o  = vpn_q;
  assign ptw_req_vpn_o  = vpn_q;
  assign entry_valid_o  = valid_q;
  assign refill_done_o  = write_go;
  assign refill_fault_o = fault_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed self-checking bench for itlb_refill_ctrl: refill latency,
// victim order and round-robin wrap, faults, flush in every state, reset.
`ifndef MXLEN
`define MXLEN 64
`endif

module tb_itlb_refill_ctrl;

  localparam int EN = 31;
  localparam int VW = 27;
  localparam int PW = `MXLEN;

  logic          clk;
  logic          rstn;
  logic          miss_valid;
  logic [VW-1:0] miss_vpn;
  logic          miss_ready;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [VW-1:0] req_vpn;
  logic          resp_valid;
  logic [PW-1:0] resp_pte;
  logic          resp_fault;
  logic [EN-1:0] wr_en;
  logic [PW-1:0] pte_wr;
  logic [VW-1:0] vpn_wr;
  logic [EN-1:0] entry_valid;
  logic          done;
  logic          fault;

  int total;
  int bad;

  itlb_refill_ctrl dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .miss_valid_i     (miss_valid),
    .miss_vpn_i       (miss_vpn),
    .miss_ready_o     (miss_ready),
    .flush_i          (flush),
    .ptw_req_valid_o  (req_valid),
    .ptw_req_ready_i  (req_ready),
    .ptw_req_vpn_o    (req_vpn),
    .ptw_resp_valid_i (resp_valid),
    .ptw_resp_pte_i   (resp_pte),
    .ptw_resp_fault_i (resp_fault),
    .itlb_wr_en_o     (wr_en),
    .itlb_pte_wr_o    (pte_wr),
    .itlb_vpn_wr_o    (vpn_wr),
    .entry_valid_o    (entry_valid),
    .refill_done_o    (done),
    .refill_fault_o   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    miss_valid = 0; miss_vpn = '0; flush = 0; req_ready = 0;
    resp_valid = 0; resp_pte = '0; resp_fault = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    clear_inputs();
    @(negedge clk);
    rstn = 1;
  endtask

  // Immediate-ready, immediate-response refill; returns what the WRITE cycle shows.
  task automatic refill(input logic [VW-1:0] vpn, input logic [PW-1:0] pte,
                        output logic [EN-1:0] wr, output logic dn);
    @(negedge clk);
    miss_valid = 1; miss_vpn = vpn; req_ready = 1; resp_valid = 1;
    resp_pte = pte; resp_fault = 0; flush = 0;
    @(negedge clk);
    miss_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    wr = wr_en;
    dn = done;
    resp_valid = 0; req_ready = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    clear_inputs();
    #1;
    total++;
    if ({req_valid, wr_en, entry_valid, done, fault, req_vpn, pte_wr, vpn_wr} !== '0) begin
      bad++; $display("FAIL reset_outputs got nonzero output");
    end
    total++;
    if (miss_ready !== 1'b1) begin bad++; $display("FAIL reset_miss_ready got=%b exp=1", miss_ready); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    #1;
    total++;
    if (miss_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", miss_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h1234; req_ready = 1; resp_valid = 1;
    resp_pte = 64'h2000_00CF;
    #1;
    total++;
    if (miss_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", miss_ready); end
    @(negedge clk);
    miss_valid = 0;
    #1;
    total++;
    if (req_valid !== 1'b1 || req_vpn !== 27'h1234) begin
      bad++; $display("FAIL basic_req got=%b/%h exp=1/1234", req_valid, req_vpn);
    end
    @(negedge clk);
    #1;
    total++;
    if (wr_en !== '0) begin bad++; $display("FAIL basic_early_write got=%h exp=0", wr_en); end
    @(negedge clk);
    #1;
    total++;
    if (wr_en !== 31'h1 || pte_wr !== 64'h2000_00CF || vpn_wr !== 27'h1234 || done !== 1'b1) begin
      bad++; $display("FAIL basic_write got wr=%h pte=%h vpn=%h done=%b exp 1/200000cf/1234/1",
                      wr_en, pte_wr, vpn_wr, done);
    end
    resp_valid = 0; req_ready = 0;
    @(negedge clk);
    #1;
    total++;
    if (entry_valid !== 31'h1 || done !== 1'b0 || wr_en !== '0) begin
      bad++; $display("FAIL basic_after got valid=%h done=%b wr=%h exp 1/0/0", entry_valid, done, wr_en);
    end
  endtask

  task automatic test_rr_wrap();
    logic [EN-1:0] wr, exp;
    logic dn;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      refill(VW'(i + 100), PW'(i) << 10, wr, dn);
      exp = (i < 31) ? (31'h1 << i) : ((i == 31) ? 31'h1 : 31'h2);
      total++;
      if (wr !== exp || dn !== 1'b1) begin
        bad++; $display("FAIL rr_miss%0d got wr=%h done=%b exp wr=%h done=1", i, wr, dn, exp);
      end
      if (i == 30) begin
        @(negedge clk);
        #1;
        total++;
        if (entry_valid !== '1) begin bad++; $display("FAIL rr_all_valid got=%h exp=7fffffff", entry_valid); end
      end
    end
  endtask

  task automatic test_fault();
    logic [EN-1:0] wr;
    logic dn;
    do_reset();
    refill(27'h10, 64'hABC, wr, dn);
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h20; req_ready = 1; resp_fault = 1;
    @(negedge clk);
    miss_valid = 0;
    @(negedge clk);
    resp_valid = 1;
    #1;
    total++;
    if (wr_en !== '0) begin bad++; $display("FAIL fault_wait_wr got=%h exp=0", wr_en); end
    @(negedge clk);
    resp_valid = 0; resp_fault = 0;
    #1;
    total++;
    if (fault !== 1'b1 || wr_en !== '0 || done !== 1'b0 || entry_valid !== 31'h1) begin
      bad++; $display("FAIL fault_pulse got f=%b wr=%h d=%b v=%h exp 1/0/0/1", fault, wr_en, done, entry_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL fault_single got=%b exp=0", fault); end
  endtask

  task automatic test_flush_wait();
    logic [EN-1:0] wr;
    logic dn;
    do_reset();
    refill(27'h30, 64'h111, wr, dn);
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h31; req_ready = 1;
    @(negedge clk);
    miss_valid = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; resp_valid = 1; resp_pte = 64'hFF;
    #1;
    total++;
    if (wr_en !== '0 || done !== 1'b0) begin
      bad++; $display("FAIL flushwait_resp got wr=%h done=%b exp 0/0", wr_en, done);
    end
    @(negedge clk);
    resp_valid = 0;
    #1;
    total++;
    if (wr_en !== '0 || done !== 1'b0 || entry_valid !== '0 || miss_ready !== 1'b1 || fault !== 1'b0) begin
      bad++; $display("FAIL flushwait_after got wr=%h d=%b v=%h rdy=%b f=%b exp 0/0/0/1/0",
                      wr_en, done, entry_valid, miss_ready, fault);
    end
    refill(27'h32, 64'h222, wr, dn);
    total++;
    if (wr !== 31'h1) begin bad++; $display("FAIL flushwait_next got=%h exp=1", wr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h5A5A; req_ready = 0;
    @(negedge clk);
    miss_valid = 0; miss_vpn = 27'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (req_valid !== 1'b1 || req_vpn !== 27'h5A5A) begin
        bad++; $display("FAIL stall_cyc%0d got=%b/%h exp=1/5a5a", k, req_valid, req_vpn);
      end
      @(negedge clk);
    end
    req_ready = 1;
    @(negedge clk);
    req_ready = 0; resp_valid = 1; resp_pte = 64'h77;
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b1 || wr_en !== 31'h1 || vpn_wr !== 27'h5A5A || pte_wr !== 64'h77) begin
      bad++; $display("FAIL stall_write got d=%b wr=%h vpn=%h pte=%h exp 1/1/5a5a/77", done, wr_en, vpn_wr, pte_wr);
    end
    resp_valid = 0;
  endtask

  task automatic test_flush_miss();
    do_reset();
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h44; flush = 1;
    #1;
    total++;
    if (miss_ready !== 1'b0) begin bad++; $display("FAIL flushmiss_ready got=%b exp=0", miss_ready); end
    @(negedge clk);
    miss_valid = 0; flush = 0;
    #1;
    total++;
    if (req_valid !== 1'b0 || miss_ready !== 1'b1) begin
      bad++; $display("FAIL flushmiss_req got=%b rdy=%b exp 0/1", req_valid, miss_ready);
    end
  endtask

  task automatic test_flush_write();
    logic [EN-1:0] wr;
    logic dn;
    do_reset();
    refill(27'h50, 64'h1, wr, dn);
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h51; req_ready = 1; resp_valid = 1; resp_pte = 64'h2;
    @(negedge clk);
    miss_valid = 0;
    @(negedge clk);
    @(negedge clk);
    flush = 1;
    #1;
    total++;
    if (wr_en !== '0 || done !== 1'b0) begin
      bad++; $display("FAIL flushwrite_wr got wr=%h done=%b exp 0/0", wr_en, done);
    end
    @(negedge clk);
    flush = 0; resp_valid = 0; req_ready = 0;
    #1;
    total++;
    if (entry_valid !== '0) begin bad++; $display("FAIL flushwrite_valid got=%h exp=0", entry_valid); end
  endtask

  task automatic test_flush_req();
    do_reset();
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h60; req_ready = 0;
    @(negedge clk);
    miss_valid = 0; flush = 1;
    #1;
    total++;
    if (req_valid !== 1'b1) begin bad++; $display("FAIL flushreq_hold got=%b exp=1", req_valid); end
    @(negedge clk);
    flush = 0; req_ready = 1;
    @(negedge clk);
    req_ready = 0; resp_valid = 1; resp_pte = 64'h99;
    #1;
    total++;
    if (req_valid !== 1'b0 || wr_en !== '0) begin
      bad++; $display("FAIL flushreq_wait got req=%b wr=%h exp 0/0", req_valid, wr_en);
    end
    @(negedge clk);
    resp_valid = 0;
    #1;
    total++;
    if (done !== 1'b0 || wr_en !== '0 || entry_valid !== '0 || miss_ready !== 1'b1) begin
      bad++; $display("FAIL flushreq_drop got d=%b wr=%h v=%h rdy=%b exp 0/0/0/1", done, wr_en, entry_valid, miss_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    miss_valid = 1; miss_vpn = 27'h70; req_ready = 1; resp_valid = 1; resp_pte = 64'h55;
    @(negedge clk);
    miss_valid = 0;
    @(negedge clk);
    #1;
    rstn = 0;
    #1;
    total++;
    if (req_valid !== 1'b0 || wr_en !== '0 || done !== 1'b0 || vpn_wr !== '0) begin
      bad++; $display("FAIL midreset_async got req=%b wr=%h d=%b vpn=%h exp all 0", req_valid, wr_en, done, vpn_wr);
    end
    @(negedge clk);
    rstn = 1; resp_valid = 0; req_ready = 0;
    @(negedge clk);
    #1;
    total++;
    if (entry_valid !== '0 || done !== 1'b0 || miss_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_after got v=%h d=%b rdy=%b exp 0/0/1", entry_valid, done, miss_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_rr_wrap();
    test_fault();
    test_flush_wait();
    test_req_stall();
    test_flush_miss();
    test_flush_write();
    test_flush_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
